// File: rtl/fifo_ctl.sv
// Bounded one-push/one-pop circular FIFO with valid/ready handshakes, occupancy count,
// almost-full/almost-empty flags, synchronous flush and optional fall-through bypass.
module fifo_ctl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_TH    = 14,
    parameter int AEMPTY_TH   = 1,
    parameter int FALLTHROUGH = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push_valid,
    input  logic [WIDTH-1:0]      push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [WIDTH-1:0]      pop_data,
    input  logic                  pop_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_TH_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0]         AE_TH_C  = CW'(AEMPTY_TH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam bit                    FT_MODE  = (FALLTHROUGH != 0);

    if (DEPTH_LOG2 < 1) begin : g_bad_depth
        $error("fifo_ctl: DEPTH_LOG2 must be >= 1");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_ctl: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $error("fifo_ctl: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] front_reg, front_next;
    logic [DEPTH_LOG2-1:0] back_reg, back_next;
    logic [CW-1:0]         count_reg, count_next;

    logic empty, full, bypass, push_acc, pop_acc, bypass_acc, store, take;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == DEPTH_C);
    // Bypass only applies while nothing is stored, so ordering is never violated.
    assign bypass     = FT_MODE && empty;

    assign push_ready = !full;
    assign pop_valid  = bypass ? push_valid : !empty;
    assign pop_data   = bypass ? push_data  : mem[front_reg];

    assign push_acc   = push_valid && push_ready;
    assign pop_acc    = pop_valid && pop_ready;
    assign bypass_acc = bypass && push_acc && pop_acc;
    assign store      = push_acc && !bypass_acc;
    assign take       = pop_acc && !bypass_acc;

    always_comb begin
        front_next = front_reg;
        back_next  = back_reg;
        count_next = count_reg;
        if (flush) begin
            front_next = '0;
            back_next  = '0;
            count_next = '0;
        end else begin
            if (store) back_next  = back_reg + PTR_ONE;
            if (take)  front_next = front_reg + PTR_ONE;
            case ({store, take})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            front_reg <= '0;
            back_reg  <= '0;
            count_reg <= '0;
        end else begin
            front_reg <= front_next;
            back_reg  <= back_next;
            count_reg <= count_next;
        end
    end

    // Storage is deliberately left out of reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (!rst && !flush && store) begin
            mem[back_reg] <= push_data;
        end
    end

    assign count        = count_reg;
    assign almost_full  = (count_reg >= AF_TH_C);
    assign almost_empty = (count_reg <= AE_TH_C);
endmodule

// File: tb/tb_fifo_ctl.sv
// Directed self-checking bench for fifo_ctl: registered-output instance plus a fall-through instance.
module tb_fifo_ctl;
    logic       clk = 1'b0;
    logic       rst, flush, push_valid, pop_ready, push_ready, pop_valid, almost_full, almost_empty;
    logic [7:0] push_data, pop_data;
    logic [2:0] count;
    logic       f_flush, f_push_valid, f_pop_ready, f_push_ready, f_pop_valid, f_almost_full, f_almost_empty;
    logic [7:0] f_push_data, f_pop_data;
    logic [2:0] f_count;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_ctl #(.WIDTH(8), .DEPTH_LOG2(2), .AFULL_TH(3), .AEMPTY_TH(1), .FALLTHROUGH(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty));

    fifo_ctl #(.WIDTH(8), .DEPTH_LOG2(2), .AFULL_TH(3), .AEMPTY_TH(1), .FALLTHROUGH(1)) dut_ft (
        .clk(clk), .rst(rst), .flush(f_flush), .push_valid(f_push_valid), .push_data(f_push_data),
        .push_ready(f_push_ready), .pop_valid(f_pop_valid), .pop_data(f_pop_data), .pop_ready(f_pop_ready),
        .count(f_count), .almost_full(f_almost_full), .almost_empty(f_almost_empty));

    // Advance one edge; inputs are then driven 2 time units after it, checks 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
        n_tests++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
        n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
        n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
        n_tests++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL reset_ft_count: got %0d expected 0", f_count); end
        $display("[TB] reset done: count=%0d push_ready=%b pop_valid=%b", count, push_ready, pop_valid);
    endtask

    task automatic test_empty_push();
        push_valid = 1'b1; push_data = 8'h66; pop_ready = 1'b1;
        #1;
        n_tests++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL empty_push_pop_valid: got %b expected 0", pop_valid); end
        step();
        push_valid = 1'b0;
        #1;
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL empty_push_count: got %0d expected 1", count); end
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'h66) begin n_fail++; $display("FAIL empty_push_head: got v=%b d=%h expected v=1 d=66", pop_valid, pop_data); end
        step();
        pop_ready = 1'b0;
        #1;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL empty_push_drain: got %0d expected 0", count); end
        $display("[TB] empty push: 0x66 stored then popped");
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic       exp_af  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_ae  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1; push_data = vals[i];
            step();
            push_valid = 1'b0;
            #1;
            n_tests++; if (count !== exp_cnt[i]) begin n_fail++; $display("FAIL fill_count%0d: got %0d expected %0d", i, count, exp_cnt[i]); end
            n_tests++; if (almost_full !== exp_af[i] || almost_empty !== exp_ae[i]) begin n_fail++; $display("FAIL fill_flags%0d: got af=%b ae=%b expected af=%b ae=%b", i, almost_full, almost_empty, exp_af[i], exp_ae[i]); end
            $display("[TB] push %h: count=%0d push_ready=%b", vals[i], count, push_ready);
        end
        n_tests++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_push_ready: got %b expected 0", push_ready); end
        pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (pop_valid !== 1'b1 || pop_data !== vals[i]) begin n_fail++; $display("FAIL drain%0d: got v=%b d=%h expected v=1 d=%h", i, pop_valid, pop_data, vals[i]); end
            $display("[TB] pop %h", pop_data);
            step();
        end
        pop_ready = 1'b0;
        #1;
        n_tests++; if (count !== 3'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got count=%0d v=%b expected 0 0", count, pop_valid); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        pop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_data = 8'h11 * 8'(i + 1);
            step();
        end
        push_data = 8'h55; pop_ready = 1'b1;
        #1;
        n_tests++; if (push_ready !== 1'b0 || pop_data !== 8'h11) begin n_fail++; $display("FAIL fullpp_head: got rdy=%b d=%h expected rdy=0 d=11", push_ready, pop_data); end
        step();
        pop_ready = 1'b0;
        #1;
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullpp_count3: got %0d expected 3", count); end
        step();
        push_valid = 1'b0;
        #1;
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpp_count4: got %0d expected 4", count); end
        pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (pop_valid !== 1'b1 || pop_data !== exp[i]) begin n_fail++; $display("FAIL fullpp_order%0d: got v=%b d=%h expected v=1 d=%h", i, pop_valid, pop_data, exp[i]); end
            step();
        end
        pop_ready = 1'b0;
        $display("[TB] full push/pop: order 22 33 44 55 checked");
    endtask

    task automatic test_wrap();
        pop_ready = 1'b0;
        push_valid = 1'b1; push_data = 8'hA0; step();
        push_data = 8'hA1; step();
        pop_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_data = 8'hA2 + 8'(i);
            #1;
            n_tests++; if (pop_data !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL wrap_data%0d: got %h expected %h", i, pop_data, 8'hA0 + 8'(i)); end
            step();
            n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count%0d: got %0d expected 2", i, count); end
            $display("[TB] wrap %0d: popped %h count=%0d", i, 8'hA0 + 8'(i), count);
        end
        push_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++; if (pop_data !== 8'hAA + 8'(i)) begin n_fail++; $display("FAIL wrap_tail%0d: got %h expected %h", i, pop_data, 8'hAA + 8'(i)); end
            step();
        end
        pop_ready = 1'b0;
    endtask

    task automatic test_flush();
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_data = 8'h30 + 8'(i); step();
        end
        flush = 1'b1; push_data = 8'h99;
        #1;
        n_tests++; if (pop_valid !== 1'b1 || push_ready !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got v=%b rdy=%b cnt=%0d expected 1 1 3", pop_valid, push_ready, count); end
        step();
        flush = 1'b0; push_valid = 1'b0;
        #1;
        n_tests++; if (count !== 3'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post: got cnt=%0d v=%b expected 0 0", count, pop_valid); end
        push_valid = 1'b1; push_data = 8'hA5; step();
        push_valid = 1'b0;
        #1;
        n_tests++; if (pop_valid !== 1'b1 || pop_data !== 8'hA5 || count !== 3'd1) begin n_fail++; $display("FAIL flush_next: got v=%b d=%h cnt=%0d expected 1 a5 1", pop_valid, pop_data, count); end
        pop_ready = 1'b1; step(); pop_ready = 1'b0;
        $display("[TB] flush: count cleared, next pop a5");
    endtask

    task automatic test_fallthrough();
        f_push_valid = 1'b1; f_push_data = 8'h7E; f_pop_ready = 1'b1;
        #1;
        n_tests++; if (f_pop_valid !== 1'b1 || f_pop_data !== 8'h7E) begin n_fail++; $display("FAIL ft_bypass: got v=%b d=%h expected 1 7e", f_pop_valid, f_pop_data); end
        step();
        #1;
        n_tests++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL ft_bypass_count: got %0d expected 0", f_count); end
        f_pop_ready = 1'b0;
        step();
        f_push_valid = 1'b0;
        #1;
        n_tests++; if (f_count !== 3'd1 || f_pop_valid !== 1'b1 || f_pop_data !== 8'h7E) begin n_fail++; $display("FAIL ft_hold: got cnt=%0d v=%b d=%h expected 1 1 7e", f_count, f_pop_valid, f_pop_data); end
        f_push_valid = 1'b1; f_push_data = 8'h3C; f_pop_ready = 1'b1;
        #1;
        n_tests++; if (f_pop_data !== 8'h7E) begin n_fail++; $display("FAIL ft_nonempty_head: got %h expected 7e", f_pop_data); end
        step();
        f_push_valid = 1'b0;
        #1;
        n_tests++; if (f_count !== 3'd1 || f_pop_data !== 8'h3C) begin n_fail++; $display("FAIL ft_second: got cnt=%0d d=%h expected 1 3c", f_count, f_pop_data); end
        step();
        f_pop_ready = 1'b0;
        #1;
        n_tests++; if (f_count !== 3'd0 || f_pop_valid !== 1'b0) begin n_fail++; $display("FAIL ft_empty: got cnt=%0d v=%b expected 0 0", f_count, f_pop_valid); end
        $display("[TB] fallthrough: bypass 7e, hold 7e, then 3c");
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        f_flush = 1'b0; f_push_valid = 1'b0; f_push_data = '0; f_pop_ready = 1'b0;
        step();
        test_reset();
        test_empty_push();
        test_fill_drain();
        test_full_pushpop();
        test_wrap();
        test_flush();
        test_fallthrough();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
